// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a
// ready-based memory handshake, with illegal-opcode and bus-timeout traps and an instret counter.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             regwrite,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             bus_error,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    logic [6:0]         r_op_q;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_instret;
    logic               r_illegal;
    logic               r_bus_error;
    logic               r_halted;
    logic               w_mem_phase;
    logic               w_timeout;
    logic               w_op_legal;
    logic               w_retire;
    logic               w_set_illegal;
    logic               w_set_bus_error;

    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEMORY);
    // Final wait cycle of a request; a simultaneous mem_ready takes priority in the FSM.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_mem_phase && !mem_ready && (r_wait == WAIT_LAST);
    assign w_op_legal  = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                         (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                         (opcode == OP_JALR) || (opcode == OP_LUI) || (opcode == OP_AUIPC);

    assign illegal   = r_illegal;
    assign bus_error = r_bus_error;
    assign halted    = r_halted;
    assign state_o   = r_state;
    assign instret   = r_instret;

    always_comb begin
        w_next          = r_state;
        w_retire        = 1'b0;
        w_set_illegal   = 1'b0;
        w_set_bus_error = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        regwrite        = 1'b0;
        pc_src          = 2'd0;
        alu_src_a       = 2'd0;
        alu_src_b       = 2'd0;
        aluop           = 2'b00;
        wb_sel          = 2'd0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_error = 1'b1;
                    w_next          = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                if (w_op_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_EXECUTE: begin
                w_next = S_WRITEBACK;
                case (r_op_q)
                    OP_R:      begin alu_src_a = 2'd1; aluop = 2'b10; end
                    OP_I:      begin alu_src_a = 2'd1; alu_src_b = 2'd2; aluop = 2'b11; end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        w_next    = S_MEMORY;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 2'd1;
                        aluop     = 2'b01;
                        pc_write  = zero;
                        pc_src    = 2'd1;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    OP_JAL:    begin pc_write = 1'b1; pc_src = 2'd1; end
                    OP_JALR: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                    end
                    OP_LUI:    begin alu_src_a = 2'd3; alu_src_b = 2'd2; end
                    OP_AUIPC:  begin alu_src_a = 2'd2; alu_src_b = 2'd2; end
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_TRAP;
                    end
                endcase
            end
            S_MEMORY: begin
                mem_req = 1'b1;
                mem_we  = (r_op_q == OP_STORE);
                if (mem_ready) begin
                    w_retire = (r_op_q == OP_STORE);
                    w_next   = (r_op_q == OP_STORE) ? S_FETCH : S_WRITEBACK;
                end else if (w_timeout) begin
                    w_set_bus_error = 1'b1;
                    w_next          = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                regwrite = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                if (r_op_q == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((r_op_q == OP_JAL) || (r_op_q == OP_JALR)) begin
                    wb_sel = 2'd2;
                end
            end
            S_TRAP: begin
                if (trap_clear) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op_q      <= '0;
            r_wait      <= '0;
            r_instret   <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op_q <= opcode;
            // Any state change restarts the wait count, covering entry to FETCH and MEMORY.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_mem_phase && !mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_retire) r_instret <= r_instret + 1'b1;
            if ((r_state == S_TRAP) && trap_clear) begin
                r_illegal   <= 1'b0;
                r_bus_error <= 1'b0;
                r_halted    <= 1'b0;
            end else begin
                if (w_set_illegal) begin
                    r_illegal <= 1'b1;
                    r_halted  <= 1'b1;
                end
                if (w_set_bus_error) begin
                    r_bus_error <= 1'b1;
                    r_halted    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a memory responder feeds random instructions,
// a reference table predicts each instruction's per-state profile, and a monitor compares them.
module tb_multicycle_control_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        trap_clear;
    logic        mem_req, mem_we, ir_write, pc_write, regwrite;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, aluop, wb_sel;
    logic        illegal, bus_error, halted;
    logic [2:0]  state_o;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .regwrite(regwrite), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .wb_sel(wb_sel), .illegal(illegal),
        .bus_error(bus_error), .halted(halted), .state_o(state_o), .instret(instret)
    );

    typedef struct { bit is_fetch; int waits; logic [6:0] op; bit z; } req_t;
    typedef struct {
        int fc; int dc; int ec; int mc; int wc; int kind; int rw; int wbs; int jw; int jsrc;
        int mwe; int mreq; int irw; int ea; int eb; int eop; int ir_end;
    } exp_t;

    req_t rq[$];
    exp_t eq[$];
    int   checks = 0;
    int   errors = 0;
    int   model_ir = 0;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference profile of one instruction, straight from the ISA-level control rules.
    function automatic exp_t predict(input logic [6:0] op, input bit z, input int fw,
                                     input int mw, input int ir_before);
        exp_t e;
        bit   legal = 1'b1;
        bit   ldst  = 1'b0;
        bit   wr    = 1'b0;
        e = '{default: 0};
        case (op)
            7'b0110011: begin e.ea = 1; e.eop = 2; wr = 1; end
            7'b0010011: begin e.ea = 1; e.eb = 2; e.eop = 3; wr = 1; end
            7'b0000011: begin e.ea = 1; e.eb = 2; ldst = 1; wr = 1; e.wbs = 1; end
            7'b0100011: begin e.ea = 1; e.eb = 2; ldst = 1; e.mwe = 1 + mw; end
            7'b1100011: begin e.ea = 1; e.eop = 1; e.jw = z ? 1 : 0; e.jsrc = 1; end
            7'b1101111: begin e.jw = 1; e.jsrc = 1; wr = 1; e.wbs = 2; end
            7'b1100111: begin e.ea = 1; e.eb = 2; e.jw = 1; e.jsrc = 2; wr = 1; e.wbs = 2; end
            7'b0110111: begin e.ea = 3; e.eb = 2; wr = 1; end
            7'b0010111: begin e.ea = 2; e.eb = 2; wr = 1; end
            default:    legal = 1'b0;
        endcase
        e.fc   = 1 + fw;
        e.dc   = 1;
        e.irw  = 1;
        e.mreq = 1 + fw;
        if (!legal) begin
            e.kind   = 1;
            e.ir_end = ir_before;
        end else begin
            e.ec     = 1;
            e.mc     = ldst ? 1 + mw : 0;
            e.mreq  += e.mc;
            e.wc     = wr ? 1 : 0;
            e.rw     = e.wc;
            e.ir_end = ir_before + 1;
        end
        return e;
    endfunction

    task automatic push_instr(input logic [6:0] op, input bit z, input int fw, input int mw);
        exp_t e;
        rq.push_back('{is_fetch: 1'b1, waits: fw, op: op, z: z});
        if (op == 7'b0000011 || op == 7'b0100011)
            rq.push_back('{is_fetch: 1'b0, waits: mw, op: 7'd0, z: 1'b0});
        e = predict(op, z, fw, mw, model_ir);
        eq.push_back(e);
        model_ir = e.ir_end;
    endtask

    // Memory/IR responder: serves queued requests after their wait counts.
    int pend = 0;
    bit issued = 0;
    bit scramble = 0;
    initial forever begin
        req_t r;
        @(negedge clk);
        if (!rst_n) begin
            mem_ready = 1'b0; pend = 0; issued = 0;
            continue;
        end
        if (scramble) begin opcode = 7'($urandom); scramble = 0; end
        if (issued) begin
            r = rq.pop_front();
            if (r.is_fetch) begin opcode = r.op; zero = r.z; scramble = 1; end
            pend = 0; issued = 0;
        end
        if (mem_req && rq.size() > 0) begin
            mem_ready = (pend >= rq[0].waits);
            issued    = mem_ready;
            pend++;
        end else if (mem_req) begin
            mem_ready = 1'b0;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: builds a per-instruction profile between FETCH entries (or TRAP entry).
    int cnt [7];
    int m_rw, m_rwbad, m_wbs, m_jw, m_jsrc, m_mwe, m_mreq, m_irw, m_fbad;
    int m_fa, m_fb, m_fop, m_da, m_db, m_ea, m_eb, m_eop;
    bit inprog = 0;
    int prev = 0;

    task automatic finalize();
        exp_t e;
        if (eq.size() == 0) begin chk("unexpected_instr", 1, 0); return; end
        e = eq.pop_front();
        chk("fetch_cycles", cnt[1], e.fc);
        chk("decode_cycles", cnt[2], e.dc);
        chk("exec_cycles", cnt[3], e.ec);
        chk("mem_cycles", cnt[4], e.mc);
        chk("wb_cycles", cnt[5], e.wc);
        chk("mem_req_cycles", m_mreq, e.mreq);
        chk("mem_we_cycles", m_mwe, e.mwe);
        chk("ir_write_cnt", m_irw, e.irw);
        chk("fetch_pc_bad", m_fbad, 0);
        chk("fetch_alu", m_fa * 100 + m_fb * 10 + m_fop, 10);
        chk("regwrite_cnt", m_rw, e.rw);
        chk("regwrite_outside_wb", m_rwbad, 0);
        if (e.rw != 0) chk("wb_sel", m_wbs, e.wbs);
        chk("jump_pc_write", m_jw, e.jw);
        if (e.jw != 0) chk("jump_pc_src", m_jsrc, e.jsrc);
        if (e.dc != 0) chk("decode_alu", m_da * 10 + m_db, 22);
        if (e.ec != 0) chk("exec_alu", m_ea * 100 + m_eb * 10 + m_eop, e.ea * 100 + e.eb * 10 + e.eop);
        chk("instret", int'(instret), e.ir_end);
        chk("illegal_flag", int'(illegal), (e.kind == 1) ? 1 : 0);
        chk("bus_error_flag", int'(bus_error), (e.kind == 2) ? 1 : 0);
        chk("halted_flag", int'(halted), (e.kind != 0) ? 1 : 0);
    endtask

    initial forever begin
        int s;
        @(negedge clk);
        #2;
        if (!rst_n) begin inprog = 0; prev = 0; continue; end
        s = int'(state_o);
        if (((s == 1 && prev != 1) || (s == 6 && prev != 6)) && inprog) begin
            finalize();
            inprog = 0;
        end
        if (s == 1 && prev != 1) begin
            inprog = 1;
            for (int i = 0; i < 7; i++) cnt[i] = 0;
            m_rw = 0; m_rwbad = 0; m_wbs = 0; m_jw = 0; m_jsrc = 0; m_mwe = 0; m_mreq = 0;
            m_irw = 0; m_fbad = 0; m_fa = 0; m_fb = 0; m_fop = 0; m_da = 0; m_db = 0;
            m_ea = 0; m_eb = 0; m_eop = 0;
        end
        if (inprog) begin
            cnt[s]++;
            if (mem_req) m_mreq++;
            if (mem_we) m_mwe++;
            if (s == 1) begin
                if (ir_write) m_irw++;
                if ((pc_write != ir_write) || (pc_write && pc_src != 2'd0)) m_fbad++;
                if (cnt[1] == 1) begin m_fa = alu_src_a; m_fb = alu_src_b; m_fop = aluop; end
            end else begin
                if (ir_write) m_fbad++;
                if (pc_write) begin m_jw++; m_jsrc = pc_src; end
            end
            if (regwrite) begin m_rw++; m_wbs = wb_sel; if (s != 5) m_rwbad++; end
            if (s == 2) begin m_da = alu_src_a; m_db = alu_src_b; end
            if (s == 3) begin m_ea = alu_src_a; m_eb = alu_src_b; m_eop = aluop; end
        end
        prev = s;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_ctrl"}, int'({mem_req, mem_we, ir_write, pc_write, regwrite}), 0);
        chk({tag, "_mux"}, int'({pc_src, alu_src_a, alu_src_b, aluop, wb_sel}), 0);
        chk({tag, "_flags"}, int'({illegal, bus_error, halted}), 0);
        chk({tag, "_instret"}, int'(instret), 0);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 5000) begin @(negedge clk); n++; end
        chk({tag, "_halt_reached"}, int'(halted), 1);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        trap_clear = 1'b1;
        @(negedge clk);
        trap_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0; trap_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        push_instr(7'b0110011, 1'b0, 0, 0);
        push_instr(7'b0000011, 1'b0, 0, 3);
        push_instr(7'b1100011, 1'b1, 0, 0);
        push_instr(7'b1100011, 1'b0, 0, 0);
        push_instr(7'b1100111, 1'b0, 0, 0);
        push_instr(7'b0110111, 1'b0, 0, 0);
        push_instr(7'b1101111, 1'b1, 1, 0);
        push_instr(7'b0010011, 1'b0, 2, 0);
        push_instr(7'b0100011, 1'b0, 0, 2);
        push_instr(7'b0010111, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++)
            push_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        push_instr(7'b1111111, 1'b0, 1, 0);
        rst_n = 1'b1;

        wait_halt("illegal");
        chk("illegal_drained", eq.size(), 0);
        chk("illegal_state", int'(state_o), 6);
        chk("illegal_set", int'(illegal), 1);
        chk("illegal_instret", int'(instret), model_ir);
        eq.push_back('{fc: TO, dc: 0, ec: 0, mc: 0, wc: 0, kind: 2, rw: 0, wbs: 0, jw: 0,
                       jsrc: 0, mwe: 0, mreq: TO, irw: 0, ea: 0, eb: 0, eop: 0, ir_end: model_ir});
        pulse_clear();
        chk("clear_state", int'(state_o), 0);
        chk("clear_flags", int'({illegal, bus_error, halted}), 0);
        chk("clear_instret", int'(instret), model_ir);

        wait_halt("timeout");
        chk("timeout_drained", eq.size(), 0);
        chk("timeout_bus_error", int'(bus_error), 1);
        chk("timeout_illegal", int'(illegal), 0);

        rq.push_back('{is_fetch: 1'b1, waits: 0, op: 7'b0100011, z: 1'b0});
        rq.push_back('{is_fetch: 1'b0, waits: 10, op: 7'd0, z: 1'b0});
        pulse_clear();
        n = 0;
        while (state_o != 3'd4 && n < 100) begin @(negedge clk); n++; end
        chk("store_reached_memory", int'(state_o), 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_store");
        repeat (2) @(negedge clk);
        rq.delete();
        model_ir = 0;
        push_instr(7'b0110011, 1'b0, 1, 0);
        rst_n = 1'b1;
        n = 0;
        while (eq.size() > 0 && n < 100) begin @(negedge clk); n++; end
        chk("restart_drained", eq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM for the RV32I core; it replaces the single-cycle combinational opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback, and stalls on a ready-based memory handshake. It adds JALR/LUI/AUIPC, illegal-opcode and bus-timeout traps, and a retired-instruction counter. It drives the datapath muxes and enables for PC, IR, ALU, data memory and the register file.

## Interface
- TIMEOUT_CYCLES, 15: max wait cycles for mem_ready per request; 0 disables the timeout.
- CNT_W, 32: width of instret.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  instr[6:0] from the IR, valid from DECODE onward.
- zero  in  1  ALU equal flag, sampled in EXECUTE for branches.
- mem_ready  in  1  memory completes the current request this cycle.
- trap_clear  in  1  leave TRAP.
- mem_req / mem_we  out  1 / 1  memory request / store.
- ir_write, pc_write, regwrite  out  1 each  register enables.
- pc_src  out  2  0 = ALU result (PC+4), 1 = target register, 2 = ALU result (JALR).
- alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC, 3 = zero.
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = imm.
- aluop  out  2  00 add, 01 sub/compare, 10 R-funct, 11 I-funct.
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4.
- illegal, bus_error, halted  out  1 each  sticky trap flags.
- state_o  out  3  current state encoding.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEMORY = 4, WRITEBACK = 5, TRAP = 6.
- Outputs are decoded from the registered state and the opcode latched in DECODE (op_q). Any control not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH next cycle.
- FETCH: mem_req = 1, a = 0, b = 1, aluop = 00.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, then DECODE.
- DECODE: a = 2, b = 2 (the target register captures old PC + imm); op_q <= opcode.
  - Unsupported opcode: illegal <= 1, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE, by op_q:
  - R (0110011): a = 1, b = 0, aluop = 10, then WRITEBACK.
  - I-ALU (0010011): a = 1, b = 2, aluop = 11, then WRITEBACK.
  - LOAD (0000011) / STORE (0100011): a = 1, b = 2, aluop = 00, then MEMORY.
  - BRANCH (1100011): a = 1, b = 0, aluop = 01. If zero = 1: pc_write = 1, pc_src = 1. The instruction retires and the FSM returns to FETCH.
  - JAL (1101111): pc_write = 1, pc_src = 1, then WRITEBACK with wb_sel = 2.
  - JALR (1100111): a = 1, b = 2, aluop = 00, pc_write = 1, pc_src = 2, then WRITEBACK with wb_sel = 2.
  - LUI (0110111): a = 3, b = 2, then WRITEBACK with wb_sel = 0.
  - AUIPC (0010111): a = 2, b = 2, then WRITEBACK with wb_sel = 0.
- MEMORY: mem_req = 1; mem_we = 1 for STORE. Hold until mem_ready.
  - STORE retires and goes to FETCH.
  - LOAD goes to WRITEBACK with wb_sel = 1.
- WRITEBACK: regwrite = 1, instruction retires, then FETCH.
- Retire: instret increments by 1 and wraps modulo 2^CNT_W.
- Timeout:
  - Wait counter clears on entry to FETCH or MEMORY and counts each cycle with mem_req = 1 and mem_ready = 0.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0: bus_error <= 1, go to TRAP.
  - mem_ready in the same cycle wins over timeout.
- TRAP: halted = 1, all other controls 0, illegal/bus_error held.
  - trap_clear = 1 clears all flags and goes to IDLE.
  - instret is not changed.

## Timing
- Async reset: state = IDLE, op_q = 0, wait counter = 0, instret = 0, all flags 0, therefore every output is 0.
- Reset asserted mid-instruction aborts it immediately; no retire, no write enables.
- Zero-wait memory latency (FETCH entry to next FETCH entry):
  - BRANCH: 3 cycles.
  - R, I-ALU, STORE, JAL, JALR, LUI, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- The memory handshake completes on the edge where mem_req and mem_ready are both 1. mem_req holds until then.
- mem_ready while mem_req = 0 is ignored.
- instret updates on the edge leaving the retiring state.
- Trap flags set on the edge entering TRAP.

## Test plan
- R-type 0110011, mem_ready tied 1 → state_o 1, 2, 3, 5, 1; regwrite high only in state 5; aluop = 10 in EXECUTE; instret 0 → 1.
- LOAD with mem_ready delayed 3 cycles in MEMORY → mem_req held 4 cycles, wb_sel = 1 and regwrite = 1 in WRITEBACK, total 8 cycles.
- BRANCH with zero = 1, then with zero = 0 → pc_write = 1, pc_src = 1 only in the taken case; both take 3 cycles; instret increments by 2.
- JALR and LUI → pc_src = 2 for JALR with wb_sel = 2; alu_src_a = 3 with wb_sel = 0 for LUI.
- Illegal opcode 1111111 → TRAP after DECODE, illegal = 1, halted = 1, instret unchanged; trap_clear → IDLE, flags 0.
- Hold mem_ready = 0 in FETCH with TIMEOUT_CYCLES = 15 → bus_error = 1 after 15 wait cycles. Assert rst_n = 0 mid-MEMORY of a store → all outputs 0 at once and instret = 0.
